// File: rtl/wired_qpram_pkg.sv
// Shared types for the qpram_32x2 write-side controller and its port-B queue.
package wired_qpram_pkg;

  localparam int unsigned QPRAM_ENTRIES = 32;

  typedef logic [4:0] qpram_addr_t;
  typedef logic [1:0] qpram_data_t;

  typedef struct packed {
    logic        valid;
    qpram_addr_t addr;
    qpram_data_t data;
  } qpram_bq_entry_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } qpram_wr_state_e;

  localparam qpram_addr_t CLR_LAST_ADDR = qpram_addr_t'(QPRAM_ENTRIES - 1);

endpackage

// File: rtl/qpram_wr_fifo.sv
// Small write queue for narrow LUTRAM tables; any stored entry whose address
// matches kill_addr_i is invalidated in place rather than removed.
module qpram_wr_fifo
  import wired_qpram_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            push_i,
  input  qpram_bq_entry_t push_entry_i,
  input  logic            pop_i,
  input  logic            kill_i,
  input  qpram_addr_t     kill_addr_i,
  output qpram_bq_entry_t head_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  qpram_bq_entry_t mem_q [DEPTH];
  qpram_bq_entry_t mem_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW:0]     cnt_q, cnt_d;

  // Kill is applied to stored entries first; a same-cycle push carries its own valid bit.
  always_comb begin
    mem_d = mem_q;
    if (kill_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (mem_q[i].addr == kill_addr_i) mem_d[i].valid = 1'b0;
      end
    end
    if (push_i) mem_d[wptr_q] = push_entry_i;
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + PW'(1);
      if (pop_i)  rptr_d = rptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + (PW+1)'(1);
        2'b01:   cnt_d = cnt_q - (PW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);

endmodule

// File: rtl/qpram_wr_ctrl.sv
// Write-side controller for a qpram_32x2 table: clear sweep, A/B write merge
// and write-through forwarding onto the three read ports.
//
//   state | meaning
//   CLEAR | sweep clr_cnt 0..31 writing CLR_VAL; port A illegal, port B closed
//   RUN   | port A wins the RAM write, otherwise drain the port-B queue head
module qpram_wr_ctrl
  import wired_qpram_pkg::*;
#(
  parameter qpram_data_t CLR_VAL  = 2'b00,
  parameter int unsigned BQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  output logic        init_done_o,
  input  logic        a_we_i,
  input  qpram_addr_t a_addr_i,
  input  qpram_data_t a_data_i,
  input  logic        b_valid_i,
  output logic        b_ready_o,
  input  qpram_addr_t b_addr_i,
  input  qpram_data_t b_data_i,
  output logic        ram_wen_o,
  output qpram_addr_t ram_aw_o,
  output qpram_data_t ram_di_o,
  input  qpram_addr_t rd_addr_i [3],
  input  qpram_data_t ram_q_i   [3],
  output qpram_data_t rd_data_o [3]
);

  qpram_wr_state_e state_q, state_d;
  qpram_addr_t     clr_cnt_q, clr_cnt_d;

  logic            bq_push, bq_pop, bq_kill, bq_empty, bq_full;
  qpram_bq_entry_t bq_head, bq_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (flush_i) begin
      state_d   = CLEAR;
      clr_cnt_d = '0;
    end else if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + 5'd1;
      if (clr_cnt_q == CLR_LAST_ADDR) state_d = RUN;
    end
  end

  // Queued B writes are never issued in a flush cycle; the sweep supersedes them.
  always_comb begin
    ram_wen_o = 1'b0;
    ram_aw_o  = bq_head.addr;
    ram_di_o  = bq_head.data;
    bq_pop    = 1'b0;
    bq_kill   = 1'b0;
    unique case (state_q)
      CLEAR: begin
        ram_wen_o = 1'b1;
        ram_aw_o  = clr_cnt_q;
        ram_di_o  = CLR_VAL;
      end
      RUN: begin
        if (a_we_i) begin
          ram_wen_o = 1'b1;
          ram_aw_o  = a_addr_i;
          ram_di_o  = a_data_i;
          bq_kill   = 1'b1;
        end else if (!bq_empty && !flush_i) begin
          bq_pop    = 1'b1;
          ram_wen_o = bq_head.valid;
        end
      end
      default: ;
    endcase
  end

  assign init_done_o = (state_q == RUN);
  assign b_ready_o   = (state_q == RUN) && !bq_full;
  assign bq_push     = b_valid_i && b_ready_o;

  always_comb begin
    bq_in.valid = !(bq_kill && (a_addr_i == b_addr_i));
    bq_in.addr  = b_addr_i;
    bq_in.data  = b_data_i;
  end

  qpram_wr_fifo #(
    .DEPTH (BQ_DEPTH)
  ) u_bq (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (flush_i),
    .push_i       (bq_push),
    .push_entry_i (bq_in),
    .pop_i        (bq_pop),
    .kill_i       (bq_kill),
    .kill_addr_i  (a_addr_i),
    .head_o       (bq_head),
    .empty_o      (bq_empty),
    .full_o       (bq_full)
  );

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rd_data_o[i] = (ram_wen_o && (ram_aw_o == rd_addr_i[i])) ? ram_di_o : ram_q_i[i];
    end
  end

  a_we_in_clear: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(a_we_i && (state_q == CLEAR)));

endmodule

// File: tb/tb_qpram_wr_ctrl.sv
// Directed plus randomized bench for qpram_wr_ctrl against a queue-based
// model of the table contents and port-B commit order.
module tb_qpram_wr_ctrl;

  localparam logic [1:0] CLR_VAL = 2'b00;
  localparam int         BQ      = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       init_done;
  logic       a_we = 1'b0;
  logic [4:0] a_addr = '0;
  logic [1:0] a_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [4:0] b_addr = '0;
  logic [1:0] b_data = '0;
  logic       ram_wen;
  logic [4:0] ram_aw;
  logic [1:0] ram_di;
  logic [4:0] rd_addr [3];
  logic [1:0] ram_q   [3];
  logic [1:0] rd_data [3];

  logic [1:0] ram  [32];
  logic [1:0] seed [32];
  logic       seed_ram = 1'b0;

  typedef struct {
    logic [4:0] addr;
    logic [1:0] data;
    bit         ok;
  } bq_t;

  bq_t        mq[$];
  bit         m_run;
  int         m_sweep;
  logic [1:0] exp_mem [32];
  bit         hold0;
  bit         last_acc;
  int         vecs;
  int         errs;

  qpram_wr_ctrl #(
    .CLR_VAL  (CLR_VAL),
    .BQ_DEPTH (BQ)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .init_done_o (init_done),
    .a_we_i      (a_we),
    .a_addr_i    (a_addr),
    .a_data_i    (a_data),
    .b_valid_i   (b_valid),
    .b_ready_o   (b_ready),
    .b_addr_i    (b_addr),
    .b_data_i    (b_data),
    .ram_wen_o   (ram_wen),
    .ram_aw_o    (ram_aw),
    .ram_di_o    (ram_di),
    .rd_addr_i   (rd_addr),
    .ram_q_i     (ram_q),
    .rd_data_o   (rd_data)
  );

  always #5 clk = ~clk;

  // RAM model: holds its contents while the controller sits in reset.
  always @(posedge clk) begin
    if (seed_ram) begin
      for (int i = 0; i < 32; i++) ram[i] <= seed[i];
    end else if (rst_n && ram_wen) begin
      ram[ram_aw] <= ram_di;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) ram_q[i] = ram[rd_addr[i]];
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_sweep = 0;
    mq.delete();
  endtask

  task automatic step();
    bit         p_wen, p_rdy, p_done;
    logic [4:0] p_aw;
    logic [1:0] p_di, e_rd;
    if (!hold0) rd_addr[0] = 5'($urandom);
    rd_addr[1] = 5'($urandom);
    rd_addr[2] = 5'($urandom);
    p_aw = '0;
    p_di = '0;
    if (!m_run) begin
      p_wen  = 1'b1;
      p_aw   = 5'(m_sweep);
      p_di   = CLR_VAL;
      p_rdy  = 1'b0;
      p_done = 1'b0;
    end else begin
      p_done = 1'b1;
      p_rdy  = (mq.size() < BQ);
      p_wen  = 1'b0;
      if (a_we) begin
        p_wen = 1'b1;
        p_aw  = a_addr;
        p_di  = a_data;
      end else if (!flush && mq.size() > 0) begin
        p_wen = mq[0].ok;
        p_aw  = mq[0].addr;
        p_di  = mq[0].data;
      end
    end
    @(negedge clk);
    chk("ram_wen", 8'(ram_wen), 8'(p_wen));
    if (p_wen) begin
      chk("ram_aw", 8'(ram_aw), 8'(p_aw));
      chk("ram_di", 8'(ram_di), 8'(p_di));
    end
    chk("b_ready", 8'(b_ready), 8'(p_rdy));
    chk("init_done", 8'(init_done), 8'(p_done));
    for (int i = 0; i < 3; i++) begin
      e_rd = (p_wen && p_aw == rd_addr[i]) ? p_di : exp_mem[rd_addr[i]];
      chk($sformatf("rd_data%0d", i), 8'(rd_data[i]), 8'(e_rd));
    end
    @(posedge clk);
    last_acc = b_valid && p_rdy;
    if (p_wen) exp_mem[p_aw] = p_di;
    if (flush) begin
      model_reset();
    end else if (!m_run) begin
      m_sweep++;
      if (m_sweep == 32) begin
        m_run   = 1'b1;
        m_sweep = 0;
      end
    end else begin
      if (a_we) begin
        foreach (mq[i]) if (mq[i].addr == a_addr) mq[i].ok = 1'b0;
      end else if (mq.size() > 0) begin
        void'(mq.pop_front());
      end
      if (b_valid && p_rdy) mq.push_back('{b_addr, b_data, !(a_we && a_addr == b_addr)});
    end
    #1;
  endtask

  task automatic idle();
    a_we    = 1'b0;
    b_valid = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_mem%0d", tag, i), 8'(ram[i]), 8'(exp_mem[i]));
  endtask

  initial begin
    int pushes;
    vecs  = 0;
    errs  = 0;
    hold0 = 1'b0;
    for (int i = 0; i < 3; i++) rd_addr[i] = '0;
    for (int i = 0; i < 32; i++) begin
      seed[i]    = 2'($urandom);
      exp_mem[i] = seed[i];
    end
    model_reset();

    // Reset release and full clear sweep.
    seed_ram = 1'b1;
    @(posedge clk);
    #1 seed_ram = 1'b0;
    @(negedge clk);
    chk("rst_init_done", 8'(init_done), 8'h0);
    chk("rst_b_ready", 8'(b_ready), 8'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (33) step();
    check_mem("sweep");
    for (int i = 0; i < 32; i++) chk($sformatf("clr%0d", i), 8'(ram[i]), 8'(CLR_VAL));

    // Single B write with forwarding on read port 0.
    hold0 = 1'b1;
    rd_addr[0] = 5'd5;
    b_valid = 1'b1; b_addr = 5'd5; b_data = 2'b11;
    step();
    b_valid = 1'b0;
    step();
    hold0 = 1'b0;
    step();
    chk("b5_ram", 8'(ram[5]), 8'h3);

    // B entries for 7 and 8 held back by A, then A overwrites 7.
    a_we = 1'b1; a_addr = 5'd20; a_data = 2'b01;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 2'b01;
    step();
    b_addr = 5'd8; b_data = 2'b10;
    step();
    b_valid = 1'b0;
    a_addr = 5'd7; a_data = 2'b11;
    step();
    idle();
    repeat (4) step();
    chk("a7_final", 8'(ram[7]), 8'h3);
    chk("b8_final", 8'(ram[8]), 8'h2);

    // Continuous A traffic fills the queue; drain in order afterwards.
    pushes = 0;
    a_we = 1'b1; a_addr = 5'd31;
    b_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      a_data = 2'($urandom);
      b_addr = 5'(10 + pushes);
      b_data = 2'(pushes);
      step();
      if (last_acc) pushes++;
    end
    chk("bq_fill_pushes", 8'(pushes), 8'd4);
    idle();
    repeat (6) step();
    check_mem("drain");

    // Flush with three entries queued.
    a_we = 1'b1; a_addr = 5'd30; a_data = 2'b10;
    b_valid = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      b_addr = 5'(c); b_data = 2'b11;
      step();
    end
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (33) step();
    check_mem("flush");

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 500; c++) begin
      flush   = ($urandom_range(0, 79) == 0);
      a_we    = m_run && ($urandom_range(0, 1) == 0);
      a_addr  = 5'($urandom_range(0, 7));
      a_data  = 2'($urandom);
      b_valid = ($urandom_range(0, 3) != 0);
      b_addr  = 5'($urandom_range(0, 7));
      b_data  = 2'($urandom);
      step();
    end
    idle();
    repeat (40) step();
    check_mem("rand");

    // Asynchronous reset at sweep count 17.
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (17) step();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_init_done", 8'(init_done), 8'h0);
    chk("midrst_b_ready", 8'(b_ready), 8'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (33) step();
    check_mem("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
